// File: rtl/gray_switch_pkg.sv
// Shared types and defaults for the Gray-coded rotary switch conditioner.
package gray_switch_pkg;

  typedef enum logic [1:0] {
    STABLE = 2'd0,
    COMMIT = 2'd1,
    COUNT  = 2'd2
  } state_t;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 270000;

  function automatic logic [2:0] popcount4(input logic [3:0] w);
    return {2'b00, w[0]} + {2'b00, w[1]} + {2'b00, w[2]} + {2'b00, w[3]};
  endfunction

endpackage

// File: rtl/gray_switch_conditioner_sync_ff.sv
// Single-bit synchronizer chain; the raw switch bit enters at stage 0.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gray_switch_conditioner.sv
// Synchronizes and debounces a 4-bit Gray switch, flagging accepted codes that
// jump by more than one bit.
//
// state  | meaning
// STABLE | sync word matches the accepted code
// COUNT  | candidate code seen, counting consecutive stable cycles
// COMMIT | candidate held long enough, accepted on the next edge
module gray_switch_conditioner
  import gray_switch_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_a,
  input  logic sw_b,
  input  logic sw_c,
  input  logic sw_d,
  output logic ag,
  output logic bg,
  output logic cg,
  output logic dg,
  output logic code_valid,
  output logic gray_err,
  output logic busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0] sw_raw;
  logic [3:0] sync_w;
  logic [3:0] out_w;
  logic [3:0] cand_w;
  logic [3:0] cand_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic commit;
  state_t state;
  state_t state_nxt;

  assign sw_raw = {sw_a, sw_b, sw_c, sw_d};

  for (genvar i = 0; i < 4; i++) begin : g_sync
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (sw_raw[i]),
      .q   (sync_w[i])
    );
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand_w;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    unique case (state)
      STABLE: begin
        if (sync_w != out_w) begin
          cand_nxt  = sync_w;
          cnt_nxt   = '0;
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        if (sync_w == out_w) begin
          state_nxt = STABLE;
        end else if (sync_w != cand_w) begin
          cand_nxt = sync_w;
          cnt_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = COMMIT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      COMMIT: begin
        // Input is ignored here; any new change is caught from STABLE.
        commit    = 1'b1;
        state_nxt = STABLE;
      end
      default: state_nxt = STABLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= STABLE;
      out_w      <= '0;
      cand_w     <= '0;
      cnt        <= '0;
      code_valid <= 1'b0;
      gray_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cand_w     <= cand_nxt;
      cnt        <= cnt_nxt;
      code_valid <= commit;
      gray_err   <= commit && (popcount4(out_w ^ cand_w) > 3'd1);
      if (commit) out_w <= cand_w;
    end
  end

  assign {ag, bg, cg, dg} = out_w;
  assign busy = (state == COUNT) || (state == COMMIT);

endmodule

// File: tb/tb_gray_switch_conditioner.sv
// Bench for gray_switch_conditioner: run-length reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_gray_switch_conditioner;

  localparam int S = 2;
  localparam int D = 4;
  localparam int LAT = S + D + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] sw = 4'b0000;
  logic ag, bg, cg, dg, code_valid, gray_err, busy;

  int tests = 0;
  int fails = 0;
  int n_valid = 0;

  // Reference model: a delay line for the synchronizer, and a code is accepted
  // once the same non-current word has been observed D+1 edges in a row.
  logic [3:0] m_q [S];
  logic [3:0] m_out = 4'b0000;
  logic [3:0] m_run_val = 4'b0000;
  logic [3:0] m_pend_val = 4'b0000;
  int m_run_len = 0;
  bit m_pend = 1'b0;
  bit m_valid = 1'b0;
  bit m_err = 1'b0;
  bit m_busy = 1'b0;

  gray_switch_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_a       (sw[3]),
    .sw_b       (sw[2]),
    .sw_c       (sw[1]),
    .sw_d       (sw[0]),
    .ag         (ag),
    .bg         (bg),
    .cg         (cg),
    .dg         (dg),
    .code_valid (code_valid),
    .gray_err   (gray_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] obs;
    if (rst) begin
      for (int i = 0; i < S; i++) m_q[i] = 4'b0000;
      m_out = 4'b0000;
      m_run_len = 0;
      m_run_val = 4'b0000;
      m_pend = 1'b0;
      m_valid = 1'b0;
      m_err = 1'b0;
    end else begin
      obs = m_q[S-1];
      m_valid = 1'b0;
      m_err = 1'b0;
      if (m_pend) begin
        m_valid = 1'b1;
        m_err = ($countones(m_out ^ m_pend_val) > 1);
        m_out = m_pend_val;
        m_pend = 1'b0;
        m_run_len = 0;
      end else if (obs == m_out) begin
        m_run_len = 0;
      end else begin
        if (m_run_len > 0 && obs == m_run_val) m_run_len++;
        else begin
          m_run_val = obs;
          m_run_len = 1;
        end
        if (m_run_len == D + 1) begin
          m_pend = 1'b1;
          m_pend_val = obs;
        end
      end
      for (int i = S - 1; i > 0; i--) m_q[i] = m_q[i-1];
      m_q[0] = sw;
    end
    m_busy = m_pend || (m_run_len > 0);
  endtask

  initial begin
    for (int i = 0; i < S; i++) m_q[i] = 4'b0000;
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("out", {ag, bg, cg, dg}, m_out);
      check("code_valid", code_valid, m_valid);
      check("gray_err", gray_err, m_err);
      check("busy", busy, m_busy);
      if (code_valid) n_valid++;
    end
  end

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (code_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    sw = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int lat;
    int v0;
    bit busy_seen;

    // reset and idle
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", code_valid, 1'b0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_out", {ag, bg, cg, dg}, 4'b0000);
    check("idle_valid_count", n_valid, 0);

    // clean single-bit step
    sw = 4'b0001;
    wait_valid(lat);
    check("step_latency", lat, LAT);
    check("step_lit_latency", lat, 8);
    check("step_out", {ag, bg, cg, dg}, 4'b0001);
    check("step_err", gray_err, 1'b0);
    check("step_model_out", m_out, 4'b0001);

    // bounce back to old code
    reset_pulse();
    v0 = n_valid;
    busy_seen = 1'b0;
    @(negedge clk);
    sw = 4'b0001;
    repeat (2) @(negedge clk);
    sw = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (busy) busy_seen = 1'b1;
    end
    @(negedge clk);
    check("bounce_no_valid", n_valid - v0, 0);
    check("bounce_busy_seen", busy_seen, 1'b1);
    check("bounce_busy_end", busy, 1'b0);
    check("bounce_out", {ag, bg, cg, dg}, 4'b0000);

    // chatter between 0001 and 0011, then settle on 0011
    v0 = n_valid;
    for (int k = 0; k < 5; k++) begin
      sw = (k % 2 == 0) ? 4'b0001 : 4'b0011;
      repeat (2) @(negedge clk);
    end
    sw = 4'b0011;
    wait_valid(lat);
    check("chatter_latency", lat, 8);
    check("chatter_out", {ag, bg, cg, dg}, 4'b0011);
    repeat (10) @(negedge clk);
    check("chatter_single_valid", n_valid - v0, 1);
    check("chatter_model_out", m_out, 4'b0011);

    // illegal multi-bit jump
    reset_pulse();
    sw = 4'b0101;
    wait_valid(lat);
    check("jump_latency", lat, 8);
    check("jump_err", gray_err, 1'b1);
    check("jump_out", {ag, bg, cg, dg}, 4'b0101);
    check("jump_model_err", m_err, 1'b1);

    // reset in the middle of a pending change
    reset_pulse();
    v0 = n_valid;
    sw = 4'b0001;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out", {ag, bg, cg, dg}, 4'b0000);
    check("abort_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check("abort_no_valid", n_valid - v0, 0);
    wait_valid(lat);
    check("abort_relatch_latency", lat, 8);
    check("abort_relatch_out", {ag, bg, cg, dg}, 4'b0001);

    // randomized segments checked by the model
    for (int seg = 0; seg < 250; seg++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) sw = 4'($urandom_range(0, 15));
      else sw = sw ^ (4'b0001 << $urandom_range(0, 3));
      repeat ($urandom_range(0, 9)) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
